lab4_sys_net_router_switch_unit: RTL and testbench



---
 rtl/lab4_sys_net_router_switch_unit_pkg.sv | 53 +++++
 rtl/lab4_sys_net_router_switch_queue.sv | 53 +++++
 rtl/lab4_sys_net_router_switch_unit.sv | 90 +++++++++
 tb/tb_lab4_sys_net_router_switch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lab4_sys_net_router_switch_unit_pkg.sv
// Shared network package for the ring router switch unit:
// port indices, port count, message header and arbiter helpers.
package lab4_sys_net_router_switch_unit_pkg;

  localparam int N_PORTS = 3;

  localparam logic [1:0] LOCAL = 2'd0;
  localparam logic [1:0] CW    = 2'd1;
  localparam logic [1:0] CCW   = 2'd2;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] src;
    logic [7:0] opaque;
  } net_msg_hdr_t;

  function automatic logic [1:0] port_inc(
    input logic [1:0] p
  );
    return (p == CCW) ? LOCAL : p + 2'd1;
  endfunction

  // First valid input found scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [N_PORTS-1:0] rr_pick(
    input logic [N_PORTS-1:0] val,
    input logic [1:0]         ptr
  );
    logic [N_PORTS-1:0] g;
    logic [1:0]         p;
    g = '0;
    p = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      if (g == '0 && val[p]) g[p] = 1'b1;
      p = port_inc(p);
    end
    return g;
  endfunction

  function automatic logic [7:0] trace_char(
    input logic [N_PORTS-1:0] g
  );
    logic [7:0] c;
    c = " ";
    unique case (1'b1)
      g[0]:    c = "0";
      g[1]:    c = "1";
      g[2]:    c = "2";
      default: c = " ";
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lab4_sys_net_router_switch_queue.sv
// Two-entry output FIFO of the switch unit; head drives the
// output stream straight from storage registers.
import lab4_sys_net_router_switch_unit_pkg::*;

module lab4_sys_net_router_switch_queue #(
  parameter int p_msg_nbits = 44
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   space,
  output logic                   deq_val,
  output logic [p_msg_nbits-1:0] deq_msg,
  input  logic                   deq_rdy
);

  logic [p_msg_nbits-1:0] mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   enq;
  logic                   deq;

  assign deq_val = (count != 2'd0);
  assign deq_msg = mem[rd_ptr];
  assign deq     = deq_val && deq_rdy;
  assign space   = (count < 2'd2) ||
                   (count == 2'd2 && deq);
  assign enq     = enq_val && space;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // When full, the write slot equals the slot being drained.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/lab4_sys_net_router_switch_unit.sv
// Ring router switch unit: round-robin merge of three inputs.
// Optional LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN grant counters.
import lab4_sys_net_router_switch_unit_pkg::*;

module lab4_sys_net_router_switch_unit #(
  parameter int p_msg_nbits = 44
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_msg_nbits-1:0] istream_msg [N_PORTS],
  input  logic [N_PORTS-1:0]     istream_val,
  output logic [N_PORTS-1:0]     istream_rdy,
  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy
`ifdef LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN
  ,
  output logic [15:0]            grant_count [N_PORTS]
`endif
);

  logic [1:0]             ptr;
  logic                   space;
  logic [N_PORTS-1:0]     grant;
  logic [1:0]             gidx;
  logic [p_msg_nbits-1:0] enq_msg;

  always_comb begin
    grant = '0;
    if (space) grant = rr_pick(istream_val, ptr);
  end

  // Reset gates ready so nothing handshakes while held.
  assign istream_rdy = reset ? grant : '0;

  always_comb begin
    enq_msg = '0;
    gidx    = LOCAL;
    unique case (1'b1)
      grant[0]: begin
        enq_msg = istream_msg[0];
        gidx    = LOCAL;
      end
      grant[1]: begin
        enq_msg = istream_msg[1];
        gidx    = CW;
      end
      grant[2]: begin
        enq_msg = istream_msg[2];
        gidx    = CCW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= LOCAL;
    end else if (|grant) begin
      ptr <= port_inc(gidx);
    end
  end

  lab4_sys_net_router_switch_queue #(
    .p_msg_nbits(p_msg_nbits)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (|grant),
    .enq_msg (enq_msg),
    .space   (space),
    .deq_val (ostream_val),
    .deq_msg (ostream_msg),
    .deq_rdy (ostream_rdy)
  );

`ifdef LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PORTS; i++)
        grant_count[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++)
        if (grant[i] && grant_count[i] != 16'hFFFF)
          grant_count[i] <= grant_count[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab4_sys_net_router_switch_unit.sv
// Scoreboard bench for the router switch unit: directed
// vectors push expected messages, a monitor pops on output.
module tb_lab4_sys_net_router_switch_unit;

  logic        clk;
  logic        reset;
  logic [43:0] imsg [3];
  logic [2:0]  ival;
  logic [2:0]  irdy;
  logic [43:0] omsg;
  logic        oval;
  logic        ordy;
`ifdef LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN
  logic [15:0] gc [3];
`endif

  int checks   = 0;
  int failures = 0;
  logic [43:0] sb [$];

  lab4_sys_net_router_switch_unit #(
    .p_msg_nbits(44)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (imsg),
    .istream_val (ival),
    .istream_rdy (irdy),
    .ostream_msg (omsg),
    .ostream_val (oval),
    .ostream_rdy (ordy)
`ifdef LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN
    ,
    .grant_count (gc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One cycle: drive, check ready mid-cycle, log grant.
  task automatic cyc(input logic [2:0]  v,
                     input logic [43:0] m0,
                     input logic [43:0] m1,
                     input logic [43:0] m2,
                     input logic        r,
                     input logic [2:0]  exp,
                     input bit          push);
    ival    = v;
    imsg[0] = m0;
    imsg[1] = m1;
    imsg[2] = m2;
    ordy    = r;
    @(negedge clk);
    chk("istream_rdy", {61'd0, irdy}, {61'd0, exp});
    if (push) begin
      if (exp[0]) sb.push_back(m0);
      if (exp[1]) sb.push_back(m1);
      if (exp[2]) sb.push_back(m2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n    = 0;
    ival = '0;
    ordy = 1'b1;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("drain_oval", {63'd0, oval}, 64'd0);
  endtask

  initial begin : monitor
    logic [43:0] e;
    forever begin
      @(negedge clk);
      if (reset && oval && ordy) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra got=%h want=none", omsg);
        end else begin
          e = sb.pop_front();
          if (omsg !== e) begin
            failures++;
            $display("FAIL sb_order got=%h want=%h",
                     omsg, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset   = 1'b0;
    ival    = 3'b111;
    ordy    = 1'b1;
    imsg[0] = 44'h0;
    imsg[1] = 44'h0;
    imsg[2] = 44'h0;
    #3;
    chk("rst_oval", {63'd0, oval}, 64'd0);
    chk("rst_rdy", {61'd0, irdy}, 64'd0);
    @(negedge clk);
    ival = '0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // all three valid: A,B,C,A,B,C one per cycle
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b001, 1);
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b010, 1);
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b100, 1);
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b001, 1);
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b010, 1);
    cyc(3'b111, 44'hA, 44'hB, 44'hC, 1, 3'b100, 1);
    drain();

    // ptr -> 1, then input 2 alone, then input 0 wins
    cyc(3'b001, 44'hD, 44'hE, 44'hF, 1, 3'b001, 1);
    cyc(3'b100, 44'hD, 44'hE, 44'hF, 1, 3'b100, 1);
    cyc(3'b111, 44'hD, 44'hE, 44'hF, 1, 3'b001, 1);
    drain();

    // output stalled: only two accepted from input 1
    cyc(3'b010, 44'h0, 44'h61, 44'h0, 0, 3'b010, 1);
    cyc(3'b010, 44'h0, 44'h62, 44'h0, 0, 3'b010, 1);
    cyc(3'b010, 44'h0, 44'h63, 44'h0, 0, 3'b000, 1);
    cyc(3'b010, 44'h0, 44'h63, 44'h0, 0, 3'b000, 1);
    chk("stall_oval", {63'd0, oval}, 64'd1);
    chk("stall_head", {20'd0, omsg}, 64'h61);
    drain();

    // full FIFO with enqueue and dequeue together
    cyc(3'b001, 44'h71, 44'h0, 44'h0, 0, 3'b001, 1);
    cyc(3'b001, 44'h72, 44'h0, 44'h0, 0, 3'b001, 1);
    cyc(3'b001, 44'h73, 44'h0, 44'h0, 1, 3'b001, 1);
    cyc(3'b001, 44'h74, 44'h0, 44'h0, 1, 3'b001, 1);
    cyc(3'b001, 44'h75, 44'h0, 44'h0, 0, 3'b000, 1);
    drain();

    // async reset with one message buffered
    cyc(3'b100, 44'h0, 44'h0, 44'h81, 0, 3'b100, 0);
    ival = '0;
    chk("pre_rst_oval", {63'd0, oval}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_flush", {63'd0, oval}, 64'd0);
    ival    = 3'b111;
    imsg[0] = 44'h90;
    imsg[1] = 44'h91;
    imsg[2] = 44'h92;
    ordy    = 1'b1;
    #1;
    chk("rdy_in_rst", {61'd0, irdy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("post_rst_oval", {63'd0, oval}, 64'd0);
    chk("first_grant", {61'd0, irdy}, 64'd1);
    sb.push_back(44'h90);
    @(posedge clk);
    #1;
    cyc(3'b111, 44'h90, 44'h91, 44'h92, 1, 3'b010, 1);
    drain();

`ifdef LAB4_SYS_NET_ROUTER_SWITCH_UNIT_STATS_EN
    @(negedge clk);
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(3'b010, 44'h0, 44'h1, 44'h2, 1, 3'b010, 1);
    cyc(3'b100, 44'h0, 44'h1, 44'h2, 1, 3'b100, 1);
    for (int i = 0; i < 70000; i++)
      cyc(3'b001, 44'(i), 44'h1, 44'h2, 1, 3'b001, 1);
    drain();
    chk("gc0_sat", {48'd0, gc[0]}, 64'hFFFF);
    chk("gc1", {48'd0, gc[1]}, 64'd1);
    chk("gc2", {48'd0, gc[2]}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
